// File: rtl/gpio_pad_pkg.sv
// Shared constants and helpers for the GPIO pad input filter.
// Imported by the lane and the top level.
package gpio_pad_pkg;

    localparam int GPIO_SYNC_STAGES_DEF = 2;
    localparam int GPIO_DEBOUNCE_DEF    = 16;

    // Counter must hold 0..debounce-1 and never be narrower than one bit.
    function automatic int gpio_cnt_width(input int debounce);
        return $clog2(debounce + 1);
    endfunction

endpackage

// File: rtl/gpio_pad_filter_lane.sv
// Single-pin lane: synchroniser, debounce counter, stable level
// and registered rise/fall pulses.
module gpio_pad_filter_lane
    import gpio_pad_pkg::*;
#(
    parameter int   SYNC_STAGES     = GPIO_SYNC_STAGES_DEF,
    parameter int   DEBOUNCE_CYCLES = GPIO_DEBOUNCE_DEF,
    parameter logic RESET_LEVEL     = 1'b0
) (
    input  logic i_clock,
    input  logic i_rst_n,
    input  logic i_raw,
    input  logic i_we,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    localparam int CW = gpio_cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] C_MAX = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] C_ONE = CW'(1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [CW-1:0]          r_cnt;
    logic                   r_stable;
    logic                   r_rise;
    logic                   r_fall;

    logic w_sync;
    logic w_diff;
    logic w_done;
    logic w_load;

    assign w_sync = r_sync[SYNC_STAGES-1];
    assign w_diff = w_sync ^ r_stable;
    assign w_done = (r_cnt == C_MAX);
    // Driven pins track the pad directly; others need a full stable run.
    assign w_load = i_we | (w_diff & w_done);

    always_ff @(posedge i_clock or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync <= {SYNC_STAGES{RESET_LEVEL}};
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_raw};
        end
    end

    always_ff @(posedge i_clock or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_stable <= RESET_LEVEL;
            r_cnt    <= '0;
        end else if (w_load) begin
            r_stable <= w_sync;
            r_cnt    <= '0;
        end else if (w_diff) begin
            r_cnt    <= r_cnt + C_ONE;
        end else begin
            r_cnt    <= '0;
        end
    end

    always_ff @(posedge i_clock or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_rise <= w_load & ~r_stable & w_sync;
            r_fall <= w_load & r_stable & ~w_sync;
        end
    end

    assign o_level = r_stable;
    assign o_rise  = r_rise;
    assign o_fall  = r_fall;

endmodule

// File: rtl/gpio_pad_filter.sv
// GPIO pad input conditioning: one independent filter lane per pin
// between the IOBUF outputs and the SoC pin read inputs.
module gpio_pad_filter
    import gpio_pad_pkg::*;
#(
    parameter int   WIDTH           = 24,
    parameter int   SYNC_STAGES     = GPIO_SYNC_STAGES_DEF,
    parameter int   DEBOUNCE_CYCLES = GPIO_DEBOUNCE_DEF,
    parameter logic RESET_LEVEL     = 1'b0
) (
    input  logic             io_clock,
    input  logic             io_reset,
    input  logic [WIDTH-1:0] io_pins_raw,
    input  logic [WIDTH-1:0] io_pins_writeEnable,
    output logic [WIDTH-1:0] io_pins_read,
    output logic [WIDTH-1:0] io_rise,
    output logic [WIDTH-1:0] io_fall
);

    genvar g;
    generate
        for (g = 0; g < WIDTH; g++) begin : g_lane
            gpio_pad_filter_lane #(
                .SYNC_STAGES     (SYNC_STAGES),
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
                .RESET_LEVEL     (RESET_LEVEL)
            ) u_lane (
                .i_clock (io_clock),
                .i_rst_n (io_reset),
                .i_raw   (io_pins_raw[g]),
                .i_we    (io_pins_writeEnable[g]),
                .o_level (io_pins_read[g]),
                .o_rise  (io_rise[g]),
                .o_fall  (io_fall[g])
            );
        end
    endgenerate

endmodule

// File: tb/tb_gpio_pad_filter.sv
// Directed bench for gpio_pad_filter with default parameters.
module tb_gpio_pad_filter;

    localparam int W = 24;

    logic         io_clock = 1'b0;
    logic         io_reset = 1'b0;
    logic [W-1:0] io_pins_raw = '0;
    logic [W-1:0] io_pins_writeEnable = '0;
    logic [W-1:0] io_pins_read;
    logic [W-1:0] io_rise;
    logic [W-1:0] io_fall;

    int checks = 0;
    int errors = 0;

    gpio_pad_filter dut (
        .io_clock            (io_clock),
        .io_reset            (io_reset),
        .io_pins_raw         (io_pins_raw),
        .io_pins_writeEnable (io_pins_writeEnable),
        .io_pins_read        (io_pins_read),
        .io_rise             (io_rise),
        .io_fall             (io_fall)
    );

    always #5 io_clock = ~io_clock;

    typedef struct {
        int   pin;
        logic we;
        int   len;
        int   exp_rise;
        int   exp_fall;
        int   win;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge io_clock);
        #1;
    endtask

    task automatic settle(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    // Index j counts edges from the first edge that samples the new raw level.
    task automatic run_vec(input vec_t v, input int idx);
        int rise_at, fall_at, nr, nf, bad, other;
        logic prev, cur;
        logic [W-1:0] m;
        string tag;
        rise_at = -1; fall_at = -1;
        nr = 0; nf = 0; bad = 0; other = 0;
        m = '1;
        m[v.pin] = 1'b0;
        prev = io_pins_read[v.pin];
        io_pins_writeEnable[v.pin] = v.we;
        for (int j = 0; j < v.win; j++) begin
            io_pins_raw[v.pin] = (j < v.len);
            step();
            cur = io_pins_read[v.pin];
            if (cur && !prev && rise_at < 0) rise_at = j;
            if (!cur && prev && fall_at < 0) fall_at = j;
            if (io_rise[v.pin]) nr++;
            if (io_fall[v.pin]) nf++;
            if (io_rise[v.pin] !== (cur && !prev)) bad++;
            if (io_fall[v.pin] !== (!cur && prev)) bad++;
            if (((io_pins_read | io_rise | io_fall) & m) != '0) other++;
            prev = cur;
        end
        io_pins_raw[v.pin] = 1'b0;
        io_pins_writeEnable[v.pin] = 1'b0;
        tag = $sformatf("v%0d_pin%0d", idx, v.pin);
        chk({tag, "_rise_edge"}, rise_at, v.exp_rise);
        chk({tag, "_fall_edge"}, fall_at, v.exp_fall);
        chk({tag, "_rise_cnt"}, nr, (v.exp_rise >= 0) ? 1 : 0);
        chk({tag, "_fall_cnt"}, nf, (v.exp_fall >= 0) ? 1 : 0);
        chk({tag, "_pulse_align"}, bad, 0);
        chk({tag, "_other_pins"}, other, 0);
        settle(25);
    endtask

    initial begin
        int bad, rise_at, nr, nf;
        logic prev;

        vecs[0] = '{pin: 3,  we: 1'b0, len: 25, exp_rise: 17, exp_fall: 42, win: 60};
        vecs[1] = '{pin: 5,  we: 1'b0, len: 15, exp_rise: -1, exp_fall: -1, win: 45};
        vecs[2] = '{pin: 5,  we: 1'b0, len: 16, exp_rise: 17, exp_fall: 33, win: 50};
        vecs[3] = '{pin: 0,  we: 1'b1, len: 1,  exp_rise: 2,  exp_fall: 3,  win: 20};
        vecs[4] = '{pin: 20, we: 1'b0, len: 1,  exp_rise: -1, exp_fall: -1, win: 30};
        vecs[5] = '{pin: 22, we: 1'b1, len: 3,  exp_rise: 2,  exp_fall: 5,  win: 20};
        vecs[6] = '{pin: 12, we: 1'b0, len: 17, exp_rise: 17, exp_fall: 34, win: 50};

        // Reset held with random pad activity.
        #2;
        chk("reset_initial_read", int'(io_pins_read), 0);
        bad = 0;
        for (int k = 0; k < 20; k++) begin
            io_pins_raw = W'($urandom);
            step();
            if ((io_pins_read | io_rise | io_fall) != '0) bad++;
        end
        chk("reset_hold_outputs", bad, 0);
        io_pins_raw = '0;
        io_reset = 1'b1;
        bad = 0;
        for (int k = 0; k < 20; k++) begin
            step();
            if ((io_pins_read | io_rise | io_fall) != '0) bad++;
        end
        chk("reset_release_quiet", bad, 0);

        for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

        // Bounce: 1x10, 0x2, 1x30; final high run starts at j=12.
        rise_at = -1; nr = 0; nf = 0;
        prev = io_pins_read[7];
        for (int j = 0; j < 56; j++) begin
            io_pins_raw[7] = (j < 10) || (j >= 12 && j < 42);
            step();
            if (io_pins_read[7] && !prev && rise_at < 0) rise_at = j;
            if (io_rise[7]) nr++;
            if (io_fall[7]) nf++;
            prev = io_pins_read[7];
        end
        io_pins_raw[7] = 1'b0;
        chk("bounce_rise_edge", rise_at, 29);
        chk("bounce_rise_cnt", nr, 1);
        chk("bounce_fall_cnt", nf, 0);
        settle(30);

        // Reset pulse mid-count discards the partial count.
        io_pins_raw[9] = 1'b1;
        settle(10);
        io_reset = 1'b0;
        #1;
        chk("midreset_read", int'(io_pins_read[9]), 0);
        step();
        io_reset = 1'b1;
        rise_at = -1; nr = 0;
        prev = io_pins_read[9];
        for (int j = 0; j < 26; j++) begin
            step();
            if (io_pins_read[9] && !prev && rise_at < 0) rise_at = j;
            if (io_rise[9]) nr++;
            prev = io_pins_read[9];
        end
        io_pins_raw[9] = 1'b0;
        chk("midreset_rise_edge", rise_at, 17);
        chk("midreset_rise_cnt", nr, 1);
        settle(30);
        chk("final_read_low", int'(io_pins_read), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/gpio_pad_filter.md
# gpio_pad_filter

Input conditioning stage between the GPIO pad buffers (`IOBUF` `O` outputs) and the SoC `io_per_gpio*_pins_read` inputs. Per pin it synchronises the asynchronous pad level into the system clock domain, rejects glitches and contact bounce shorter than a programmable number of cycles, and emits single-cycle rise/fall pulses. Pins the SoC is actively driving (`writeEnable` high) bypass the debounce so read-back of outputs stays fast.

## Interface
Parameters:
- `WIDTH`, 24: number of pins.
- `SYNC_STAGES`, 2: synchroniser flops per pin, legal range 2..4.
- `DEBOUNCE_CYCLES`, 16: consecutive stable cycles needed to accept a new level, ≥1.
- `RESET_LEVEL`, 1'b0: reset value of every flop in the synchroniser and of the stable level. It matches the board pull-down.

Ports:
- `io_clock`, input, 1: system clock; all flops rising-edge.
- `io_reset`, input, 1: **one clock; reset is asynchronous and active-low**. Asserted low clears all state immediately; deassertion is externally synchronised.
- `io_pins_raw`, input, WIDTH: pad levels from the `IOBUF` `O` outputs, asynchronous.
- `io_pins_writeEnable`, input, WIDTH: the SoC's per-pin output enable, synchronous to `io_clock`.
- `io_pins_read`, output, WIDTH: debounced level to the SoC.
- `io_rise`, output, WIDTH: one-cycle pulse when `io_pins_read[i]` goes 0→1.
- `io_fall`, output, WIDTH: one-cycle pulse when `io_pins_read[i]` goes 1→0.

## Operation
Each pin is processed by an identical, independent lane with no cross-pin interaction.

- **Synchroniser:** a `SYNC_STAGES`-deep flop chain. Its last stage is `sync[i]`.
- **Counter:** `cnt[i]`, width `$clog2(DEBOUNCE_CYCLES+1)`. Reset value 0.
- **Stable register:** `stable[i]`, which drives `io_pins_read[i]`.

Per clock edge, filter mode (`io_pins_writeEnable[i]=0`):
- `sync==stable`: `cnt<=0`.
- `sync!=stable` and `cnt<DEBOUNCE_CYCLES-1`: `cnt<=cnt+1`.
- `sync!=stable` and `cnt==DEBOUNCE_CYCLES-1`: `stable<=sync`, `cnt<=0`.
- A mismatch interrupted by even one matching cycle restarts the count from 0. Counting never accumulates across bounces.
- `cnt` never exceeds `DEBOUNCE_CYCLES-1`, so there is no wrap-around.

Per clock edge, bypass mode (`io_pins_writeEnable[i]=1`):
- `stable<=sync`, `cnt<=0` every cycle.
- Switching writeEnable 1→0 starts filtering from the current `stable` with `cnt=0`.
- Switching 0→1 mid-count discards the count.

Edge pulses:
- `io_rise[i]` and `io_fall[i]` are registered. On the same edge that `stable` updates, `rise<=~stable&sync` and `fall<=stable&~sync`; on every other edge both load 0.
- A pulse is therefore high in exactly the first cycle of the new `io_pins_read` value.
- Rise and fall are never high together.
- Pulses occur in both modes.

Reset (asynchronous, any time, including mid-count):
- Synchroniser and `stable` go to `RESET_LEVEL`; `cnt`, `io_rise` and `io_fall` go to 0.
- No pulse is generated by reset itself or on the first cycles after release.

## Timing
Outputs:
- All outputs are registered; no combinational path from inputs to outputs.
- Reset values: `io_pins_read=RESET_LEVEL` on every bit; `io_rise=0`; `io_fall=0`.

Latency, counted from a raw change sampled at edge N:
- `sync` changes after edge N+SYNC_STAGES-1.
- In filter mode, `io_pins_read` changes after edge N+SYNC_STAGES-1+DEBOUNCE_CYCLES. With defaults that is 17 edges after sampling.
- In bypass mode, `io_pins_read` changes after edge N+SYNC_STAGES.

Glitch rejection:
- A `sync` pulse of ≤ DEBOUNCE_CYCLES-1 cycles is always rejected.
- A pulse of ≥ DEBOUNCE_CYCLES cycles is always accepted.
- `DEBOUNCE_CYCLES=1` degenerates to sync plus one register stage; any level held for one sampled cycle is accepted.

## Structure
- Package `gpio_pad_pkg` holds:
  - default constants `GPIO_SYNC_STAGES_DEF=2` and `GPIO_DEBOUNCE_DEF=16`;
  - the counter-width function.
- Sub-module `gpio_pad_filter_lane` is a single-pin lane (synchroniser, counter, stable register, pulse registers). The top level instantiates it `WIDTH` times in a generate loop.
- The top level contains no other logic.

## Test plan
Defaults throughout.
- **Reset:** hold `io_reset=0` and toggle `io_pins_raw` randomly. Required: `io_pins_read=0`, `io_rise=0`, `io_fall=0` throughout; after release, no pulses while raw stays 0.
- **Clean step:** raw[3] 0→1, sampled at edge N. Required: `io_pins_read[3]` rises after edge N+17, `io_rise[3]` is high for exactly that one cycle, and other pins are unaffected.
- **Glitch boundary:**
  - raw[5] high for 15 sampled cycles: no change on `io_pins_read[5]`.
  - raw[5] high for 16 sampled cycles: it rises after edge N+17.
- **Bounce:** raw[7] pattern 1×10, 0×2, 1×30 cycles. Required: a single rise, 17 edges after the start of the final high run; no fall.
- **Bypass:** with `writeEnable[0]=1`, raw[0] 0→1→0 with 1 cycle high. Required: `io_pins_read[0]` high for 1 cycle, 2 edges late, with a rise pulse then a fall pulse.
- **Reset mid-count:** raw[9] held 1 for 10 cycles, then `io_reset` pulsed low for 1 cycle. Required: `cnt` returns to 0; the rise occurs 17 edges after the first edge following reset release, not earlier.
